// File: rtl/dtube_pkg.sv
//==============================================================================
// Module   : dtube_pkg
// Brief    : Shared digital-tube constants and scan-driver state encoding.
// Revision : 1.0
//==============================================================================
`default_nettype none

package dtube_pkg;

  localparam int         NUM_DIGITS = 6;
  localparam logic [7:0] SEG_OFF    = 8'hFF;
  localparam logic [5:0] DIG_OFF    = 6'h3F;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

`default_nettype wire

// File: rtl/dtube_scan_if.sv
//==============================================================================
// Module   : dtube_scan_if
// Brief    : Static segment codes in, multiplexed segment/digit bus out.
// Revision : 1.0
//==============================================================================
`default_nettype none

interface dtube_scan_if;

  logic       en;
  logic [3:0] brightness;
  logic [7:0] hex0;
  logic [7:0] hex1;
  logic [7:0] hex2;
  logic [7:0] hex3;
  logic [7:0] hex4;
  logic [7:0] hex5;
  logic [7:0] seg_n;
  logic [5:0] dig_n;
  logic       frame_start;

  modport master (
    output en, brightness, hex0, hex1, hex2, hex3, hex4, hex5,
    input  seg_n, dig_n, frame_start
  );

  modport slave (
    input  en, brightness, hex0, hex1, hex2, hex3, hex4, hex5,
    output seg_n, dig_n, frame_start
  );

endinterface

`default_nettype wire

// File: rtl/dtube_scan.sv
//==============================================================================
// Module   : dtube_scan
// Brief    : Six-digit time-multiplexed tube scanner with blanking and PWM.
// Revision : 1.0
//==============================================================================
`default_nettype none

module dtube_scan
  import dtube_pkg::*;
#(
  parameter int BLANK_CYCLES = 4,
  parameter int STEP_CYCLES  = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  dtube_scan_if.slave  bus
);

  localparam int            SLOT        = BLANK_CYCLES + 16 * STEP_CYCLES;
  localparam int            CW          = $clog2(SLOT);
  localparam logic [CW-1:0] C_SLOT_LAST = CW'(SLOT - 1);
  localparam logic [CW-1:0] C_BLANK     = CW'(BLANK_CYCLES);
  localparam logic [CW-1:0] C_STEP      = CW'(STEP_CYCLES);
  localparam logic [2:0]    C_DIG_LAST  = 3'(NUM_DIGITS - 1);

  state_e          r_state, w_state_nxt;
  logic [CW-1:0]   r_slot, w_slot_nxt;
  logic [2:0]      r_digit, w_digit_nxt;
  logic [3:0]      r_bright, w_bright_nxt;
  logic [7:0]      r_shadow [NUM_DIGITS];
  logic [7:0]      w_hex    [NUM_DIGITS];
  logic            w_reload;
  logic [7:0]      r_seg_n, w_seg_nxt;
  logic [5:0]      r_dig_n, w_dig_nxt;
  logic            r_frame, w_frame_nxt;
  logic [CW-1:0]   w_on_end;
  logic            w_on;

  assign w_hex[0] = bus.hex0;
  assign w_hex[1] = bus.hex1;
  assign w_hex[2] = bus.hex2;
  assign w_hex[3] = bus.hex3;
  assign w_hex[4] = bus.hex4;
  assign w_hex[5] = bus.hex5;

  // Outputs are decoded from the next-state counters so the registered
  // outputs line up with slot_cnt/digit on the very same edge.
  always_comb begin
    w_state_nxt  = r_state;
    w_slot_nxt   = r_slot;
    w_digit_nxt  = r_digit;
    w_bright_nxt = r_bright;
    w_reload     = 1'b0;
    w_frame_nxt  = 1'b0;
    w_seg_nxt    = SEG_OFF;
    w_dig_nxt    = DIG_OFF;
    w_on_end     = '0;
    w_on         = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (bus.en) begin
          w_state_nxt = ST_RUN;
          w_slot_nxt  = '0;
          w_digit_nxt = '0;
          w_reload    = 1'b1;
          w_frame_nxt = 1'b1;
        end
      end
      ST_RUN: begin
        if (!bus.en) begin
          w_state_nxt = ST_IDLE;
          w_slot_nxt  = '0;
          w_digit_nxt = '0;
        end else if (r_slot == C_SLOT_LAST) begin
          w_slot_nxt = '0;
          if (r_digit == C_DIG_LAST) begin
            w_digit_nxt = '0;
            w_reload    = 1'b1;
            w_frame_nxt = 1'b1;
          end else begin
            w_digit_nxt = r_digit + 3'd1;
          end
        end else begin
          w_slot_nxt = r_slot + CW'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if (w_state_nxt == ST_RUN && w_slot_nxt == '0)
      w_bright_nxt = bus.brightness;

    // Slot 0 is always blank, so a freshly reloaded shadow is never needed
    // on the reload edge itself.
    w_on_end = C_BLANK + CW'(w_bright_nxt) * C_STEP;
    w_on     = (w_state_nxt == ST_RUN) && (w_slot_nxt >= C_BLANK) && (w_slot_nxt < w_on_end);
    if (w_on) begin
      w_dig_nxt = ~(6'(1) << w_digit_nxt);
      w_seg_nxt = r_shadow[w_digit_nxt];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_slot   <= '0;
      r_digit  <= '0;
      r_bright <= '0;
      r_seg_n  <= SEG_OFF;
      r_dig_n  <= DIG_OFF;
      r_frame  <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) r_shadow[i] <= SEG_OFF;
    end else begin
      r_state  <= w_state_nxt;
      r_slot   <= w_slot_nxt;
      r_digit  <= w_digit_nxt;
      r_bright <= w_bright_nxt;
      r_seg_n  <= w_seg_nxt;
      r_dig_n  <= w_dig_nxt;
      r_frame  <= w_frame_nxt;
      if (w_reload)
        for (int i = 0; i < NUM_DIGITS; i++) r_shadow[i] <= w_hex[i];
    end
  end

  assign bus.seg_n       = r_seg_n;
  assign bus.dig_n       = r_dig_n;
  assign bus.frame_start = r_frame;

endmodule

`default_nettype wire

// File: doc/dtube_scan.md
# dtube_scan

Time-multiplexed scan driver that sits directly downstream of the digital-tube AHB-lite peripheral. It takes the six static active-low segment codes (DTUBE_HEX0..5) and drives them onto one shared segment bus with six active-low digit enables, for boards whose tubes share segment lines. The driver inserts anti-ghosting blanking between digits, applies 16-level brightness PWM per digit slot, and latches codes once per frame so a display never tears.

## Interface
- BLANK_CYCLES, default 4: all-off cycles at the start of each digit slot (≥1).
- STEP_CYCLES, default 64: cycles per brightness step; slot length SLOT = BLANK_CYCLES + 16*STEP_CYCLES.
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  scan enable; low forces display off and restarts the scan.
- brightness  in  4  on-time in steps per slot; 0 = dark, 15 = max.
- hex0 … hex5  in  8 each  active-low segment codes from the peripheral (bit7 = dp).
- seg_n  out  8  shared segment bus, active-low.
- dig_n  out  6  digit enables, active-low; bit i selects hex i.
- frame_start  out  1  one-cycle pulse at the first cycle of digit 0's slot.

## Operation
- States: IDLE, RUN. Reset → IDLE. IDLE→RUN on en=1; RUN→IDLE on en=0, from any phase.
- Counters in RUN: slot_cnt 0..SLOT-1 (wraps), digit 0..5 (increments on slot_cnt wrap; 5 wraps to 0).
- Entering RUN: slot_cnt=0, digit=0, frame_start=1; shadow[0..5] captured from hex0..5 on that edge.
- Shadow reload on every edge where digit wraps 5→0; frame_start=1 in the following cycle. hex changes mid-frame have no effect until the next frame.
- bright_q captured from brightness whenever slot_cnt becomes 0, so changes apply from the next slot only.
- Phase within a slot: BLANK for slot_cnt < BLANK_CYCLES; ON for BLANK_CYCLES ≤ slot_cnt < BLANK_CYCLES + bright_q*STEP_CYCLES; OFF for the rest.
- ON: dig_n = ~(6'b1 << digit), seg_n = shadow[digit]. BLANK/OFF/IDLE: dig_n = 6'h3F, seg_n = 8'hFF.
- bright_q = 0: the digit stays dark for the whole slot while the scan continues.
- Comparison widths: slot_cnt is $clog2(SLOT) bits; bright_q*STEP_CYCLES is computed at that width with no truncation, because max value < SLOT.

## Timing
- Reset values: seg_n = 8'hFF, dig_n = 6'h3F, frame_start = 0; state IDLE, counters 0, shadows 8'hFF, bright_q 0.
- All outputs are registers updated on the same edge as the counters, so they always describe the current slot_cnt/digit with zero lag.
- en sampled high at edge T: RUN from T, frame_start=1 and all-off outputs in cycle T, first digit ON at T+BLANK_CYCLES.
- en sampled low: the outputs are all-off on that same edge; counters clear; frame_start=0.
- Frame period = 6*SLOT cycles. At most one dig_n bit is low at any time. Between two different digits' ON phases there are always ≥ BLANK_CYCLES all-off cycles.
- Asynchronous reset mid-slot sets all outputs to reset values immediately.

## Structure
- Shared package dtube_pkg: NUM_DIGITS = 6, SEG_OFF = 8'hFF, DIG_OFF = 6'h3F. Use the same package for the peripheral's blank code.
- Single module; no sub-module. The prescaler is the slot_cnt itself.

## Test plan
Use BLANK_CYCLES = 4 and STEP_CYCLES = 2 (SLOT = 36).
- Reset then en=1, brightness=15, hex0..5 = C0,F9,A4,B0,99,92 → frame_start pulse; dig_n=3E, seg_n=C0 on cycles 4–33; 3F/FF on cycles 0–3 and 34–35; sequence repeats for digits 1..5; next frame_start at cycle 216.
- brightness=0 → dig_n stays 3F for the full frame while frame_start still pulses every 216 cycles.
- brightness 15→3 at slot_cnt=10 of digit 2 → digit 2 keeps 30 ON cycles; digit 3 has exactly 6 ON cycles.
- hex1 changed from F9 to 88 during digit 3 → digit 1 shows F9 for the rest of the frame and 88 from the next frame.
- en dropped during ON of digit 4 → next cycle dig_n=3F, seg_n=FF; re-enable restarts at digit 0 with a frame_start pulse.
- rst_n asserted mid-ON asynchronously → outputs FF/3F without waiting for a clock edge; the invariant of at most one dig_n bit low is checked throughout.
